tx_order_sequencer: RTL and testbench
=====================================

TX_ORDER_SEQUENCER -- requirements
Module: tx_order_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning arrival-order queue entries (power of two, >=4).
REQ-002 SHALL have parameter ID_W, default 16, meaning transaction ID width.
REQ-003 SHALL have port clk  in  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports p_push / np_push / cpl_push  in  1 each  new Posted / Non-Posted / Completion header available.
REQ-006 SHALL have ports p_ro, p_ido, np_ro, np_ido, cpl_ro, cpl_ido  in  1 each  RO / IDO attribute of the pushed header.
REQ-007 SHALL have ports p_id, np_id, cpl_id  in  ID_W each  requester/completer ID of the pushed header.
REQ-008 SHALL have port cpl_typ  in  1  completion carries the comp_typ bypass qualifier.
REQ-009 SHALL have port push_ready  out  1  high when count <= DEPTH-3.
REQ-010 SHALL have ports fc_ok_p, fc_ok_np, fc_ok_cpl  in  1 each  flow-control credits available per type.
REQ-011 SHALL have ports first_trans, second_trans  out  2 each  type of queue entry 0 / entry 1 (No_Req=0, Posted_Req=1, Non_Posted_Req=2, Comp=3).
REQ-012 SHALL have ports first_ro, first_ido, second_ro, second_ido, comp_typ  out  1 each  attributes of entries 0/1; comp_typ is entry 1's cpl_typ.
REQ-013 SHALL have ports first_trans_id, second_trans_id  out  ID_W each  IDs of entries 0/1.
REQ-014 SHALL have port ordering_result  in  1  1 = entry 1 may pass entry 0 (from ordering stage, combinational).
REQ-015 SHALL have ports grant_valid  out  1, grant_type  out  2, grant_ready  in  1  grant handshake to the TLP builder.

Function
REQ-016 Queue SHALL be an in-order shift queue; entry 0 is oldest; empty entries read as type No_Req with zero attributes/ID.
REQ-017 Same-cycle pushes SHALL be appended in fixed order P, then NP, then CPL; pushes while push_ready=0 SHALL be dropped and set sticky output overflow (out, 1), cleared only by rst.
REQ-018 Push in cycle N SHALL be visible in the queue (and on first/second ports) in cycle N+1.
REQ-019 FSM states SHALL be IDLE, DECIDE, GRANT.
REQ-020 IDLE: grant_valid=0; move to DECIDE when count>0.
REQ-021 DECIDE (one cycle): select entry 0 if its fc_ok is high; else select entry 1 if count>=2, ordering_result=1 and entry 1's fc_ok high; else stay in DECIDE with no selection.
REQ-022 On selection, SHALL register grant_type and selected index and enter GRANT next cycle.
REQ-023 GRANT: grant_valid=1, grant_type stable until grant_ready=1; on handshake remove selected entry (entries above it shift down one) and go DECIDE if count after pop >0, else IDLE.
REQ-024 Pop and pushes in the same cycle SHALL both take effect; pushes append after the shifted contents.
REQ-025 Entry-1 bypass SHALL never skip more than one entry; entries >=2 never overtake.
REQ-026 Minimum latency push->grant_valid SHALL be 2 cycles (N+1 DECIDE, N+2 GRANT).
REQ-027 fc_ok changes while in GRANT SHALL NOT revoke an issued grant.
REQ-028 count SHALL be clog2(DEPTH)+1 bits wide and never exceed DEPTH.

Reset
REQ-029 rst=1 SHALL force state IDLE, count 0, all entries No_Req/zero, grant_valid=0, grant_type=0, overflow=0, push_ready=1, next edge, overriding any push or handshake that cycle.
REQ-030 Reset asserted mid-GRANT SHALL discard the pending grant with no pop reported.

Verification
REQ-031 Single p_push, fc_ok_p=1, grant_ready=1 -> grant_valid=1, grant_type=1 at cycle N+2, queue empty at N+3, state IDLE.
REQ-032 p_push and cpl_push same cycle -> entry0=Posted, entry1=Comp; grants in that order.
REQ-033 Queue [P, NP], fc_ok_p=0, fc_ok_np=1, ordering_result=1 -> grant_type=2, P remains entry 0.
REQ-034 Same setup with ordering_result=0 -> no grant, FSM stays DECIDE until fc_ok_p=1, then grant_type=1.
REQ-035 Fill to DEPTH-2 (6) -> push_ready=0; further push sets overflow=1, count stays 6.
REQ-036 rst pulse while grant_valid=1 and grant_ready=0 -> next cycle grant_valid=0, count=0, overflow=0.

Source files
------------

// File: rtl/tx_order_sequencer.sv
// rtl/tx_order_sequencer.sv - in-order TLP arrival queue with single-entry bypass and grant handshake
module tx_order_sequencer #(
    parameter int DEPTH = 8,
    parameter int ID_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p_push,
    input  logic                    np_push,
    input  logic                    cpl_push,
    input  logic                    p_ro,
    input  logic                    p_ido,
    input  logic                    np_ro,
    input  logic                    np_ido,
    input  logic                    cpl_ro,
    input  logic                    cpl_ido,
    input  logic [ID_W-1:0]         p_id,
    input  logic [ID_W-1:0]         np_id,
    input  logic [ID_W-1:0]         cpl_id,
    input  logic                    cpl_typ,
    output logic                    push_ready,
    input  logic                    fc_ok_p,
    input  logic                    fc_ok_np,
    input  logic                    fc_ok_cpl,
    output logic [1:0]              first_trans,
    output logic [1:0]              second_trans,
    output logic                    first_ro,
    output logic                    first_ido,
    output logic                    second_ro,
    output logic                    second_ido,
    output logic                    comp_typ,
    output logic [ID_W-1:0]         first_trans_id,
    output logic [ID_W-1:0]         second_trans_id,
    input  logic                    ordering_result,
    output logic                    grant_valid,
    output logic [1:0]              grant_type,
    input  logic                    grant_ready,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_P    = 2'd1;
    localparam logic [1:0] T_NP   = 2'd2;
    localparam logic [1:0] T_CPL  = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, DECIDE = 2'd1, GRANT = 2'd2} state_t;

    state_t state_q, state_d;

    logic [1:0]      typ_q  [DEPTH];
    logic [1:0]      typ_d  [DEPTH];
    logic            ro_q   [DEPTH];
    logic            ro_d   [DEPTH];
    logic            ido_q  [DEPTH];
    logic            ido_d  [DEPTH];
    logic            ctyp_q [DEPTH];
    logic            ctyp_d [DEPTH];
    logic [ID_W-1:0] id_q   [DEPTH];
    logic [ID_W-1:0] id_d   [DEPTH];

    logic [CW-1:0] count_q, count_d, wp;
    logic          overflow_q, overflow_d;
    logic [1:0]    gtype_q;
    logic          sel_q;
    logic          pop, sel0, sel1;

    function automatic logic fc_of(input logic [1:0] t, input logic fp, input logic fnp, input logic fcpl);
        case (t)
            T_P:     fc_of = fp;
            T_NP:    fc_of = fnp;
            T_CPL:   fc_of = fcpl;
            default: fc_of = 1'b0;
        endcase
    endfunction

    assign push_ready = (count_q <= CW'(DEPTH - 3));
    assign pop        = (state_q == GRANT) && grant_ready;
    assign sel0       = fc_of(typ_q[0], fc_ok_p, fc_ok_np, fc_ok_cpl);
    assign sel1       = (count_q >= CW'(2)) && ordering_result
                        && fc_of(typ_q[1], fc_ok_p, fc_ok_np, fc_ok_cpl);

    // Pop shifts entries above the granted one down first; accepted pushes then land after that.
    always_comb begin
        typ_d  = typ_q;
        ro_d   = ro_q;
        ido_d  = ido_q;
        ctyp_d = ctyp_q;
        id_d   = id_q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel_q)) begin
                    typ_d[i]  = typ_q[i+1];
                    ro_d[i]   = ro_q[i+1];
                    ido_d[i]  = ido_q[i+1];
                    ctyp_d[i] = ctyp_q[i+1];
                    id_d[i]   = id_q[i+1];
                end
            end
            typ_d[DEPTH-1]  = T_NONE;
            ro_d[DEPTH-1]   = 1'b0;
            ido_d[DEPTH-1]  = 1'b0;
            ctyp_d[DEPTH-1] = 1'b0;
            id_d[DEPTH-1]   = '0;
        end
        wp = count_q - CW'(pop);
        if (push_ready && p_push) begin
            typ_d[wp[AW-1:0]]  = T_P;
            ro_d[wp[AW-1:0]]   = p_ro;
            ido_d[wp[AW-1:0]]  = p_ido;
            ctyp_d[wp[AW-1:0]] = 1'b0;
            id_d[wp[AW-1:0]]   = p_id;
            wp = wp + CW'(1);
        end
        if (push_ready && np_push) begin
            typ_d[wp[AW-1:0]]  = T_NP;
            ro_d[wp[AW-1:0]]   = np_ro;
            ido_d[wp[AW-1:0]]  = np_ido;
            ctyp_d[wp[AW-1:0]] = 1'b0;
            id_d[wp[AW-1:0]]   = np_id;
            wp = wp + CW'(1);
        end
        if (push_ready && cpl_push) begin
            typ_d[wp[AW-1:0]]  = T_CPL;
            ro_d[wp[AW-1:0]]   = cpl_ro;
            ido_d[wp[AW-1:0]]  = cpl_ido;
            ctyp_d[wp[AW-1:0]] = cpl_typ;
            id_d[wp[AW-1:0]]   = cpl_id;
            wp = wp + CW'(1);
        end
        count_d    = wp;
        overflow_d = overflow_q | (!push_ready && (p_push || np_push || cpl_push));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                typ_q[i]  <= T_NONE;
                ro_q[i]   <= 1'b0;
                ido_q[i]  <= 1'b0;
                ctyp_q[i] <= 1'b0;
                id_q[i]   <= '0;
            end
            count_q    <= '0;
            overflow_q <= 1'b0;
            gtype_q    <= T_NONE;
            sel_q      <= 1'b0;
        end else begin
            typ_q      <= typ_d;
            ro_q       <= ro_d;
            ido_q      <= ido_d;
            ctyp_q     <= ctyp_d;
            id_q       <= id_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (state_q == DECIDE && (sel0 || sel1)) begin
                gtype_q <= sel0 ? typ_q[0] : typ_q[1];
                sel_q   <= !sel0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE looks at the post-push count so a push reaches DECIDE in the very next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_d != '0) state_d = DECIDE;
            DECIDE:  if (sel0 || sel1) state_d = GRANT;
            GRANT:   if (grant_ready) state_d = (count_d != '0) ? DECIDE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_valid = (state_q == GRANT);
    end

    assign grant_type      = gtype_q;
    assign overflow        = overflow_q;
    assign count           = count_q;
    assign first_trans     = typ_q[0];
    assign second_trans    = typ_q[1];
    assign first_ro        = ro_q[0];
    assign first_ido       = ido_q[0];
    assign second_ro       = ro_q[1];
    assign second_ido      = ido_q[1];
    assign comp_typ        = ctyp_q[1];
    assign first_trans_id  = id_q[0];
    assign second_trans_id = id_q[1];
endmodule

// File: tb/tb_tx_order_sequencer.sv
// tb/tb_tx_order_sequencer.sv - directed table-driven bench for tx_order_sequencer
module tb_tx_order_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        p_push, np_push, cpl_push;
    logic        p_ro, p_ido, np_ro, np_ido, cpl_ro, cpl_ido;
    logic [15:0] p_id, np_id, cpl_id;
    logic        cpl_typ;
    logic        push_ready;
    logic        fc_ok_p, fc_ok_np, fc_ok_cpl;
    logic [1:0]  first_trans, second_trans;
    logic        first_ro, first_ido, second_ro, second_ido, comp_typ;
    logic [15:0] first_trans_id, second_trans_id;
    logic        ordering_result;
    logic        grant_valid;
    logic [1:0]  grant_type;
    logic        grant_ready;
    logic        overflow;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    tx_order_sequencer #(.DEPTH(8), .ID_W(16)) dut (
        .clk(clk), .rst(rst),
        .p_push(p_push), .np_push(np_push), .cpl_push(cpl_push),
        .p_ro(p_ro), .p_ido(p_ido), .np_ro(np_ro), .np_ido(np_ido),
        .cpl_ro(cpl_ro), .cpl_ido(cpl_ido),
        .p_id(p_id), .np_id(np_id), .cpl_id(cpl_id), .cpl_typ(cpl_typ),
        .push_ready(push_ready),
        .fc_ok_p(fc_ok_p), .fc_ok_np(fc_ok_np), .fc_ok_cpl(fc_ok_cpl),
        .first_trans(first_trans), .second_trans(second_trans),
        .first_ro(first_ro), .first_ido(first_ido),
        .second_ro(second_ro), .second_ido(second_ido), .comp_typ(comp_typ),
        .first_trans_id(first_trans_id), .second_trans_id(second_trans_id),
        .ordering_result(ordering_result),
        .grant_valid(grant_valid), .grant_type(grant_type), .grant_ready(grant_ready),
        .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    // push and fc fields are {cpl, np, p}
    typedef struct {
        logic [2:0] push;
        logic [2:0] fc;
        logic       ord;
        logic       gr;
        logic [1:0] ef;
        logic [1:0] es;
        logic       egv;
        logic [1:0] egt;
        int         ecnt;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mk(input logic [2:0] push, input logic [2:0] fc, input logic ord,
                                input logic gr, input logic [1:0] ef, input logic [1:0] es,
                                input logic egv, input logic [1:0] egt, input int ecnt);
        vec_t v;
        v.push = push; v.fc = fc; v.ord = ord; v.gr = gr;
        v.ef = ef; v.es = es; v.egv = egv; v.egt = egt; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(3'b001, 3'b111, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 1);
        tbl[1]  = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd1, 2'd0, 1'b1, 2'd1, 1);
        tbl[2]  = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd1, 0);
        tbl[3]  = mk(3'b101, 3'b111, 1'b0, 1'b1, 2'd1, 2'd3, 1'b0, 2'd1, 2);
        tbl[4]  = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd1, 2'd3, 1'b1, 2'd1, 2);
        tbl[5]  = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 2'd1, 1);
        tbl[6]  = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 2'd3, 1);
        tbl[7]  = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd3, 0);
        tbl[8]  = mk(3'b011, 3'b110, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 2'd3, 2);
        tbl[9]  = mk(3'b000, 3'b110, 1'b1, 1'b1, 2'd1, 2'd2, 1'b1, 2'd2, 2);
        tbl[10] = mk(3'b000, 3'b110, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 2'd2, 1);
        tbl[11] = mk(3'b000, 3'b110, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 2'd2, 1);
        tbl[12] = mk(3'b000, 3'b111, 1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 2'd1, 1);
        tbl[13] = mk(3'b000, 3'b111, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 2'd1, 0);
        tbl[14] = mk(3'b011, 3'b110, 1'b0, 1'b1, 2'd1, 2'd2, 1'b0, 2'd1, 2);
        tbl[15] = mk(3'b000, 3'b110, 1'b0, 1'b1, 2'd1, 2'd2, 1'b0, 2'd1, 2);
        tbl[16] = mk(3'b000, 3'b110, 1'b0, 1'b1, 2'd1, 2'd2, 1'b0, 2'd1, 2);
        tbl[17] = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd1, 2'd2, 1'b1, 2'd1, 2);
        tbl[18] = mk(3'b000, 3'b000, 1'b0, 1'b0, 2'd1, 2'd2, 1'b1, 2'd1, 2);
        tbl[19] = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 2'd1, 1);
        tbl[20] = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd2, 2'd0, 1'b1, 2'd2, 1);
        tbl[21] = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd2, 0);
        tbl[22] = mk(3'b011, 3'b110, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 2'd2, 2);
        tbl[23] = mk(3'b100, 3'b110, 1'b1, 1'b1, 2'd1, 2'd2, 1'b1, 2'd2, 3);
        tbl[24] = mk(3'b100, 3'b110, 1'b1, 1'b1, 2'd1, 2'd3, 1'b0, 2'd2, 3);
        tbl[25] = mk(3'b000, 3'b110, 1'b1, 1'b1, 2'd1, 2'd3, 1'b1, 2'd3, 3);
        tbl[26] = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd1, 2'd3, 1'b0, 2'd3, 2);
        tbl[27] = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd1, 2'd3, 1'b1, 2'd1, 2);
        tbl[28] = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 2'd1, 1);
        tbl[29] = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 2'd3, 1);
        tbl[30] = mk(3'b000, 3'b111, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd3, 0);

        rst = 1'b1;
        p_push = 1'b0; np_push = 1'b0; cpl_push = 1'b0;
        p_ro = 1'b0; p_ido = 1'b0; np_ro = 1'b0; np_ido = 1'b0; cpl_ro = 1'b0; cpl_ido = 1'b0;
        p_id = 16'h1111; np_id = 16'h2222; cpl_id = 16'h3333; cpl_typ = 1'b0;
        fc_ok_p = 1'b0; fc_ok_np = 1'b0; fc_ok_cpl = 1'b0;
        ordering_result = 1'b0; grant_ready = 1'b0;
        tick();
        tick();
        chk("reset grant_valid", 32'(grant_valid), 32'd0);
        chk("reset grant_type",  32'(grant_type),  32'd0);
        chk("reset count",       32'(count),       32'd0);
        chk("reset push_ready",  32'(push_ready),  32'd1);
        chk("reset overflow",    32'(overflow),    32'd0);
        chk("reset first_trans", 32'(first_trans), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 31; i++) begin
            {cpl_push, np_push, p_push}    = tbl[i].push;
            {fc_ok_cpl, fc_ok_np, fc_ok_p} = tbl[i].fc;
            ordering_result = tbl[i].ord;
            grant_ready     = tbl[i].gr;
            tick();
            chk($sformatf("row%0d first_trans", i),  32'(first_trans),  32'(tbl[i].ef));
            chk($sformatf("row%0d second_trans", i), 32'(second_trans), 32'(tbl[i].es));
            chk($sformatf("row%0d grant_valid", i),  32'(grant_valid),  32'(tbl[i].egv));
            chk($sformatf("row%0d grant_type", i),   32'(grant_type),   32'(tbl[i].egt));
            chk($sformatf("row%0d count", i),        32'(count),        32'(tbl[i].ecnt));
        end
        {cpl_push, np_push, p_push} = 3'b000;

        // attributes and IDs travel with their entries
        rst = 1'b1; tick(); rst = 1'b0;
        {fc_ok_cpl, fc_ok_np, fc_ok_p} = 3'b000;
        grant_ready = 1'b0;
        p_push = 1'b1; p_ro = 1'b1; p_ido = 1'b0; p_id = 16'hABCD;
        cpl_push = 1'b1; cpl_ro = 1'b0; cpl_ido = 1'b1; cpl_id = 16'h5A5A; cpl_typ = 1'b1;
        tick();
        p_push = 1'b0; cpl_push = 1'b0;
        chk("attr first_trans_id",  32'(first_trans_id),  32'h0000ABCD);
        chk("attr second_trans_id", 32'(second_trans_id), 32'h00005A5A);
        chk("attr first_ro",        32'(first_ro),        32'd1);
        chk("attr first_ido",       32'(first_ido),       32'd0);
        chk("attr second_ro",       32'(second_ro),       32'd0);
        chk("attr second_ido",      32'(second_ido),      32'd1);
        chk("attr comp_typ",        32'(comp_typ),        32'd1);
        chk("attr count",           32'(count),           32'd2);

        // fill to the push_ready boundary and overflow
        {cpl_push, np_push, p_push} = 3'b111;
        tick();
        chk("fill5 count",      32'(count),      32'd5);
        chk("fill5 push_ready", 32'(push_ready), 32'd1);
        {cpl_push, np_push, p_push} = 3'b001;
        tick();
        chk("fill6 count",      32'(count),      32'd6);
        chk("fill6 push_ready", 32'(push_ready), 32'd0);
        chk("fill6 overflow",   32'(overflow),   32'd0);
        {cpl_push, np_push, p_push} = 3'b010;
        tick();
        chk("ovf count",    32'(count),    32'd6);
        chk("ovf overflow", 32'(overflow), 32'd1);
        {cpl_push, np_push, p_push} = 3'b000;
        tick();
        chk("ovf sticky", 32'(overflow), 32'd1);

        // reset in the middle of an outstanding grant
        {fc_ok_cpl, fc_ok_np, fc_ok_p} = 3'b111;
        tick();
        chk("hold grant_valid", 32'(grant_valid), 32'd1);
        chk("hold grant_type",  32'(grant_type),  32'd1);
        tick();
        chk("hold2 grant_valid", 32'(grant_valid), 32'd1);
        rst = 1'b1; grant_ready = 1'b1; p_push = 1'b1;
        tick();
        rst = 1'b0; grant_ready = 1'b0; p_push = 1'b0;
        chk("rst grant_valid", 32'(grant_valid), 32'd0);
        chk("rst count",       32'(count),       32'd0);
        chk("rst overflow",    32'(overflow),    32'd0);
        chk("rst push_ready",  32'(push_ready),  32'd1);
        chk("rst grant_type",  32'(grant_type),  32'd0);
        chk("rst first_trans", 32'(first_trans), 32'd0);
        tick();
        chk("post-rst grant_valid", 32'(grant_valid), 32'd0);
        chk("post-rst count",       32'(count),       32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
